hex_scan_display: RTL and testbench

- Time-multiplexed driver for a DIGITS-digit common-anode 7-segment display.
- Keeps a shadow register of hex nibbles plus per-digit point and blank bits.
- Scans one digit at a time at a programmable rate and decodes each nibble to active-low segments, covering 0-9 and A-F.
- Adds per-digit blanking, leading-zero suppression and a registered, glitch-free output stage. Sits between the datapath and the board's segment/anode pins.

---
 rtl/hex_scan_display_if.sv | 26 ++
 rtl/hex_scan_display.sv | 114 +++++++++++
 tb/tb_hex_scan_display.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/hex_scan_display_if.sv
// Bus between the datapath and the 7-segment scan driver: shadow-load inputs
// plus the registered segment/anode/scan-index outputs.
interface hex_scan_display_if #(
   parameter int DIGITS = 4
);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic                  load;
   logic [4*DIGITS-1:0]   hex_data;
   logic [DIGITS-1:0]     point;
   logic [DIGITS-1:0]     blank;
   logic                  lz_en;
   logic [7:0]            seg;
   logic [DIGITS-1:0]     an;
   logic [IDX_W-1:0]      scan_idx;

   modport master (
      output load, hex_data, point, blank, lz_en,
      input  seg, an, scan_idx
   );

   modport slave (
      input  load, hex_data, point, blank, lz_en,
      output seg, an, scan_idx
   );
endinterface

// File: rtl/hex_scan_display.sv
// Time-multiplexed common-anode 7-segment driver with shadow register,
// per-digit blanking, leading-zero suppression and registered outputs.
module hex_scan_display #(
   parameter int DIGITS  = 4,
   parameter int CLK_DIV = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   hex_scan_display_if.slave bus
);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   logic [DIV_W-1:0]    div_cnt;
   logic [IDX_W-1:0]    idx;
   logic [4*DIGITS-1:0] sh_hex;
   logic [DIGITS-1:0]   sh_point;
   logic [DIGITS-1:0]   sh_blank;

   logic [DIGITS-1:0]   supp;
   logic                supp_run;
   logic [3:0]          nib;
   logic                dark;
   logic [7:0]          seg_nxt;
   logic [DIGITS-1:0]   an_nxt;

   logic [7:0]          seg_q;
   logic [DIGITS-1:0]   an_q;
   logic [IDX_W-1:0]    scan_idx_q;

   function automatic logic [6:0] decode(input logic [3:0] v);
      case (v)
         4'h0: decode = 7'h40;
         4'h1: decode = 7'h79;
         4'h2: decode = 7'h24;
         4'h3: decode = 7'h30;
         4'h4: decode = 7'h19;
         4'h5: decode = 7'h12;
         4'h6: decode = 7'h02;
         4'h7: decode = 7'h78;
         4'h8: decode = 7'h00;
         4'h9: decode = 7'h10;
         4'hA: decode = 7'h08;
         4'hB: decode = 7'h03;
         4'hC: decode = 7'h46;
         4'hD: decode = 7'h21;
         4'hE: decode = 7'h06;
         default: decode = 7'h0E;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         idx     <= '0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
         idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_hex   <= '0;
         sh_point <= '0;
         sh_blank <= '1;
      end else if (bus.load) begin
         sh_hex   <= bus.hex_data;
         sh_point <= bus.point;
         sh_blank <= bus.blank;
      end
   end

   // Suppression runs from the most significant digit down and stops at the
   // first non-zero nibble or lit point; digit 0 is always shown.
   always_comb begin
      supp     = '0;
      supp_run = bus.lz_en;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (supp_run && (sh_hex[4*i +: 4] == 4'h0) && !sh_point[i]) begin
            supp[i] = 1'b1;
         end else begin
            supp_run = 1'b0;
         end
      end
   end

   always_comb begin
      nib     = sh_hex[4*idx +: 4];
      dark    = sh_blank[idx] | supp[idx];
      seg_nxt = dark ? 8'hFF : {~sh_point[idx], decode(nib)};
      an_nxt  = dark ? '1 : ~(DIGITS'(1) << idx);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q      <= 8'hFF;
         an_q       <= '1;
         scan_idx_q <= '0;
      end else begin
         seg_q      <= seg_nxt;
         an_q       <= an_nxt;
         scan_idx_q <= idx;
      end
   end

   assign bus.seg      = seg_q;
   assign bus.an       = an_q;
   assign bus.scan_idx = scan_idx_q;
endmodule

// File: tb/tb_hex_scan_display.sv
// Bench for hex_scan_display (DIGITS=4, CLK_DIV=4): directed scenarios plus
// random traffic compared cycle by cycle against a frame-level model.
module tb_hex_scan_display;
   localparam int D  = 4;
   localparam int CD = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   hex_scan_display_if #(.DIGITS(D)) bus ();
   hex_scan_display #(.DIGITS(D), .CLK_DIV(CD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   logic [15:0] m_hex;
   logic [3:0]  m_point, m_blank;
   int          m_edges;
   logic [7:0]  exp_seg;
   logic [3:0]  exp_an;
   logic [1:0]  exp_idx;

   task automatic model_reset();
      m_hex = '0; m_point = '0; m_blank = '1; m_edges = 0;
   endtask

   // Drives inputs for one edge; the expected outputs after that edge follow
   // from the elapsed edge count and the shadow contents before the edge.
   task automatic step(input logic ld, input logic [15:0] hx, input logic [3:0] pt,
                       input logic [3:0] bl, input logic lz);
      int k;
      bit dark;
      bus.load = ld; bus.hex_data = hx; bus.point = pt; bus.blank = bl; bus.lz_en = lz;
      @(posedge clk);
      k    = (m_edges / CD) % D;
      dark = m_blank[k] || (lz && k >= 1 && (m_hex >> (4*k)) == 16'h0 && (m_point >> k) == 4'h0);
      exp_idx = 2'(k);
      if (dark) begin
         exp_seg = 8'hFF; exp_an = 4'hF;
      end else begin
         exp_seg = {~m_point[k], seg_tab[m_hex[4*k +: 4]]};
         exp_an  = ~(4'b0001 << k);
      end
      if (ld) begin m_hex = hx; m_point = pt; m_blank = bl; end
      m_edges++;
      #1;
   endtask

   task automatic test_reset();
      bus.load = 0; bus.hex_data = '0; bus.point = '0; bus.blank = '0; bus.lz_en = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      total++; if (bus.seg !== 8'hFF) begin bad++; $display("FAIL reset_seg got=%h exp=ff", bus.seg); end
      total++; if (bus.an !== 4'hF) begin bad++; $display("FAIL reset_an got=%b exp=1111", bus.an); end
      total++; if (bus.scan_idx !== 2'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", bus.scan_idx); end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      step(1'b1, 16'h12AF, 4'h0, 4'h0, 1'b0);
      for (int c = 0; c < 24; c++) begin
         step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom), 1'b0);
         total++;
         if ({bus.seg, bus.an, bus.scan_idx} !== {exp_seg, exp_an, exp_idx}) begin
            bad++;
            $display("FAIL basic c=%0d seg=%h/%h an=%b/%b idx=%0d/%0d", c, bus.seg, exp_seg, bus.an, exp_an, bus.scan_idx, exp_idx);
         end
      end
   endtask

   task automatic test_async_reset();
      repeat (5) step(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({bus.seg, bus.an, bus.scan_idx} !== {8'hFF, 4'hF, 2'd0}) begin
         bad++; $display("FAIL async_reset seg=%h an=%b idx=%0d exp=ff/1111/0", bus.seg, bus.an, bus.scan_idx);
      end
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(1'b1, 16'h12AF, 4'h0, 4'h0, 1'b0);
      for (int c = 0; c < 20; c++) begin
         step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom), 1'b0);
         total++;
         if ({bus.seg, bus.an, bus.scan_idx} !== {exp_seg, exp_an, exp_idx}) begin
            bad++;
            $display("FAIL post_reset c=%0d seg=%h/%h an=%b/%b idx=%0d/%0d", c, bus.seg, exp_seg, bus.an, exp_an, bus.scan_idx, exp_idx);
         end
      end
   endtask

   task automatic test_lz(input logic [3:0] pt, input string tag);
      step(1'b1, 16'h0050, pt, 4'h0, 1'b1);
      for (int c = 0; c < 20; c++) begin
         step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom), 1'b1);
         total++;
         if ({bus.seg, bus.an, bus.scan_idx} !== {exp_seg, exp_an, exp_idx}) begin
            bad++;
            $display("FAIL %s c=%0d seg=%h/%h an=%b/%b idx=%0d/%0d", tag, c, bus.seg, exp_seg, bus.an, exp_an, bus.scan_idx, exp_idx);
         end
      end
   endtask

   task automatic test_blank();
      step(1'b1, 16'h8888, 4'h0, 4'b0010, 1'b0);
      for (int c = 0; c < 20; c++) begin
         step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom), 1'b0);
         total++;
         if ({bus.seg, bus.an, bus.scan_idx} !== {exp_seg, exp_an, exp_idx}) begin
            bad++;
            $display("FAIL blank c=%0d seg=%h/%h an=%b/%b idx=%0d/%0d", c, bus.seg, exp_seg, bus.an, exp_an, bus.scan_idx, exp_idx);
         end
      end
   endtask

   task automatic test_load_on_advance();
      int guard = 0;
      while (((m_edges + 1) % (D*CD)) != 2*CD && guard < 64) begin
         step(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
         guard++;
      end
      total++;
      if (guard >= 64) begin bad++; $display("FAIL advance_sync guard=%0d limit=64", guard); end
      step(1'b1, 16'h3C5A, 4'h0, 4'h0, 1'b0);
      step(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
      total++;
      if ({bus.seg, bus.an, bus.scan_idx} !== {8'hC6, 4'b1011, 2'd2}) begin
         bad++; $display("FAIL load_on_advance seg=%h an=%b idx=%0d exp=c6/1011/2", bus.seg, bus.an, bus.scan_idx);
      end
      for (int c = 0; c < 16; c++) begin
         step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom), 1'b0);
         total++;
         if ({bus.seg, bus.an, bus.scan_idx} !== {exp_seg, exp_an, exp_idx}) begin
            bad++;
            $display("FAIL advance c=%0d seg=%h/%h an=%b/%b idx=%0d/%0d", c, bus.seg, exp_seg, bus.an, exp_an, bus.scan_idx, exp_idx);
         end
      end
   endtask

   task automatic test_sweep();
      for (int v = 0; v < 16; v++) begin
         step(1'b1, {12'h0, 4'(v)}, 4'h0, 4'b1110, 1'b0);
         for (int c = 0; c < D*CD; c++) begin
            step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom), 1'b0);
            total++;
            if ({bus.seg, bus.an, bus.scan_idx} !== {exp_seg, exp_an, exp_idx}) begin
               bad++;
               $display("FAIL sweep v=%0d c=%0d seg=%h/%h an=%b/%b idx=%0d/%0d", v, c, bus.seg, exp_seg, bus.an, exp_an, bus.scan_idx, exp_idx);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] hx;
      for (int c = 0; c < 400; c++) begin
         for (int n = 0; n < 4; n++) hx[4*n +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         step(($urandom_range(0, 7) == 0), hx, 4'($urandom & $urandom),
              4'($urandom & $urandom & $urandom), 1'($urandom));
         total++;
         if ({bus.seg, bus.an, bus.scan_idx} !== {exp_seg, exp_an, exp_idx}) begin
            bad++;
            $display("FAIL random c=%0d seg=%h/%h an=%b/%b idx=%0d/%0d", c, bus.seg, exp_seg, bus.an, exp_an, bus.scan_idx, exp_idx);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_async_reset();
      test_lz(4'b0000, "lz");
      test_lz(4'b0100, "lz_point");
      test_blank();
      test_load_on_advance();
      test_sweep();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
